imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream stage of the single-cycle core. Receives a program as a byte stream and writes it word by word into the
//  instruction memory through its write port. While loading, it holds the core stalled. When loading is done it
//  releases the core with CoreRun, so the first fetch sees the complete image.
//  Stream format: 4-byte little-endian word count N, then N little-endian 32-bit instruction words.
// PARAMETERS
//  DEPTH_WORDS  256           capacity of instruction memory, in 32-bit words
//  BASE_ADDR    32'h0000_0000 byte address of the first word written
// PORTS
//  CLK        in   1   system clock, rising edge
//  RST_N      in   1   asynchronous active-low reset
//  InValid    in   1   InByte is valid this cycle
//  InByte     in   8   stream byte
//  InReady    out  1   loader accepts a byte this cycle
//  Reload     in   1   one-cycle pulse: re-arm loader from DONE/ERR
//  IMemWE     out  1   instruction-memory write enable (one cycle per word)
//  IMemAddr   out  32  byte address of word being written
//  IMemWData  out  32  assembled instruction word
//  CoreRun    out  1   1 = core may execute; 0 = core held (PC reset/stalled)
//  Busy       out  1   1 while in HDR with >=1 byte taken, or in DATA
//  Error      out  1   sticky: header count exceeded DEPTH_WORDS
// BEHAVIOUR
//  Reset (RST_N=0, async): state=HDR, byte_cnt=0, word_cnt=0, InReady=0 until first edge after release, IMemWE=0,
//   IMemAddr=BASE_ADDR, IMemWData=0, CoreRun=0, Busy=0, Error=0. Deassertion of RST_N is sampled at the next CLK edge.
//  Handshake: a byte transfers on a rising edge where InValid&InReady=1. InReady=1 in HDR/DATA, 0 in DONE/ERR.
//   InReady does not depend on InValid. It is combinational from state only.
//  Assembly: byte_cnt (2 bits) selects the lane. Byte 0 goes to [7:0] and byte 3 goes to [31:24]. byte_cnt wraps 3->0.
//  States:
//   HDR : collect 4 bytes into N. On the 4th byte:
//         N==0 -> DONE. N>DEPTH_WORDS -> ERR. Otherwise -> DATA, word_cnt=0.
//   DATA: on the 4th byte of each word, at the same edge:
//         - IMemWData = the word, IMemAddr = BASE_ADDR + 4*word_cnt, IMemWE = 1 for exactly one cycle.
//         - word_cnt increments.
//         - When word_cnt reaches N-1 before the increment, next state = DONE.
//   DONE: CoreRun is registered 1 one edge after entering DONE, so the final write completes first. It stays 1.
//   ERR : Error=1, CoreRun=0, no writes. Only Reload or reset leaves ERR.
//  Reload pulse in DONE/ERR -> HDR at the next edge. At that edge:
//   CoreRun=0, Error=0, byte_cnt=0, word_cnt=0, IMemAddr=BASE_ADDR.
//   Reload is ignored in HDR/DATA.
//  Write timing: IMemWE is high in the cycle after the accepting edge. Back-to-back words therefore produce
//   WE pulses spaced at least 4 cycles apart. WE is never high on two consecutive cycles.
//  Widths: N is held in 32 bits. The compare against DEPTH_WORDS is unsigned. word_cnt is 32 bits and never wraps,
//   because N<=DEPTH_WORDS. Address arithmetic is modulo 2^32.
//  Gaps: InValid may drop at any cycle. Partial words and headers are held indefinitely, with no timeout.
//  Reset mid-load: everything returns to the reset state. The partial image stays in memory, and CoreRun stays 0.
// TESTING
//  1 Reset: hold RST_N=0 with traffic on InValid -> InReady=0, IMemWE=0, CoreRun=0. Release -> InReady=1 next cycle.
//  2 Load N=2, words 32'h00500093, 32'h00108113, sent back-to-back ->
//    - WE pulses at addr 0x0 then 0x4 with exactly those data values.
//    - CoreRun rises one cycle after entering DONE. InReady then goes to 0.
//  3 Header N=0 -> DONE with no IMemWE pulse, and CoreRun=1.
//  4 Header N=DEPTH_WORDS+1 (257) -> Error=1, InReady=0, no writes.
//    Then Reload -> Error=0, and a valid N=1 load works.
//  5 N=1 with InValid toggled 1,0,0,1,... -> only accepted bytes assemble correctly. The WE pulse comes after the 4th accepted byte.
//  6 RST_N asserted after 2 data bytes of word 1 -> all outputs reset immediately (async).
//    A fresh N=1 load then writes at BASE_ADDR with the correct word.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a little-endian byte stream (word count N, then N words) into
// instruction-memory writes, holding the core stalled until the full image is written.
module imem_boot_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        InValid,
  input  logic [7:0]  InByte,
  output logic        InReady,
  input  logic        Reload,
  output logic        IMemWE,
  output logic [31:0] IMemAddr,
  output logic [31:0] IMemWData,
  output logic        CoreRun,
  output logic        Busy,
  output logic        Error,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q;
  logic        armed_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic [31:0] n_q;
  logic [31:0] word_cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        run_q;
  logic        err_q;

  logic        accept;
  logic        last_byte;
  logic [31:0] full_word;

  // Valid/ready: a byte moves on a rising CLK edge where InValid && InReady.
  // InReady is a function of loader state only (never of InValid) and stays
  // low for the first edge after reset release (armed_q).
  assign InReady   = armed_q && ((state_q == S_HDR) || (state_q == S_DATA));
  assign accept    = InValid && InReady;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign full_word = {InByte, asm_q};

  assign IMemWE    = we_q;
  assign IMemAddr  = addr_q;
  assign IMemWData = wdata_q;
  assign CoreRun   = run_q;
  assign Error     = err_q;
  assign Busy      = ((state_q == S_HDR) && (byte_cnt_q != 2'd0)) || (state_q == S_DATA);
  assign DbgState  = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_HDR;
      armed_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      n_q        <= 32'd0;
      word_cnt_q <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      we_q    <= 1'b0;
      case (state_q)
        S_HDR, S_DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    asm_q[7:0]   <= InByte;
              2'd1:    asm_q[15:8]  <= InByte;
              2'd2:    asm_q[23:16] <= InByte;
              default: asm_q        <= asm_q;
            endcase
            if (last_byte && (state_q == S_HDR)) begin
              n_q        <= full_word;
              word_cnt_q <= 32'd0;
              if (full_word == 32'd0) begin
                state_q <= S_DONE;
              end else if (full_word > 32'(DEPTH_WORDS)) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end else if (last_byte) begin
              // Word complete: present it to the memory for exactly one cycle.
              we_q       <= 1'b1;
              wdata_q    <= full_word;
              addr_q     <= BASE_ADDR + (word_cnt_q << 2);
              word_cnt_q <= word_cnt_q + 32'd1;
              if (word_cnt_q == (n_q - 32'd1)) begin
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE, S_ERR: begin
          if (Reload) begin
            state_q    <= S_HDR;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 32'd0;
            addr_q     <= BASE_ADDR;
          end else if (state_q == S_DONE) begin
            // Lags DONE entry by one edge so the final write lands before the core runs.
            run_q <= 1'b1;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: reset, back-to-back load, empty and oversized
// headers, reload, gapped input and asynchronous reset in the middle of a word.
module tb_imem_boot_loader;

  logic        CLK;
  logic        RST_N;
  logic        InValid;
  logic [7:0]  InByte;
  logic        InReady;
  logic        Reload;
  logic        IMemWE;
  logic [31:0] IMemAddr;
  logic [31:0] IMemWData;
  logic        CoreRun;
  logic        Busy;
  logic        Error;
  logic [1:0]  DbgState;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic        prev_we = 1'b0;

  imem_boot_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .InValid(InValid), .InByte(InByte), .InReady(InReady),
    .Reload(Reload), .IMemWE(IMemWE), .IMemAddr(IMemAddr), .IMemWData(IMemWData),
    .CoreRun(CoreRun), .Busy(Busy), .Error(Error), .DbgState(DbgState)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // write monitor: records every WE pulse and checks WE never lasts two cycles
  always @(negedge CLK) begin
    if (IMemWE) begin
      obs_q.push_back({IMemAddr, IMemWData});
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_spacing: IMemWE high on consecutive cycles at addr %h", IMemAddr);
      end
    end
    prev_we = IMemWE;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge CLK);
    InValid = 1'b1;
    InByte  = b;
    t = 0;
    while (!InReady && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!InReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: InReady=%b required 1", InReady);
    end
    @(posedge CLK);
    #1;
    InValid = 1'b0;
    InByte  = 8'hxx;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0]);
    end
  endtask

  task automatic pulse_reload();
    @(negedge CLK);
    Reload = 1'b1;
    @(posedge CLK);
    #1;
    Reload = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic check_writes(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_write%0d: got addr/data %h, required %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      InValid = 1'($urandom_range(0, 1));
      InByte  = 8'($urandom_range(0, 255));
      #1;
      checks++;
      if ({InReady, IMemWE, CoreRun, Busy, Error} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_outputs: InReady/WE/Run/Busy/Err=%b required 00000",
                 {InReady, IMemWE, CoreRun, Busy, Error});
      end
    end
    checks++;
    if (IMemAddr !== 32'h0 || IMemWData !== 32'h0 || DbgState !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h data=%h state=%0d required 0/0/0", IMemAddr, IMemWData, DbgState);
    end
    @(negedge CLK);
    InValid = 1'b0;
    RST_N   = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: InReady=%b required 0 before first edge", InReady);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: InReady=%b required 1", InReady);
    end
    obs_q.delete();
  endtask

  task automatic test_load_two();
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_8113});
    send_word(32'd2);
    send_word(32'h0050_0093);
    send_word(32'h0010_8113);
    checks++;
    if (IMemWE !== 1'b1 || CoreRun !== 1'b0 || InReady !== 1'b0 || DbgState !== 2'd2) begin
      errors++;
      $display("FAIL load2_last_cycle: WE=%b Run=%b Ready=%b state=%0d required 1/0/0/2",
               IMemWE, CoreRun, InReady, DbgState);
    end
    wait_cycles(1);
    checks++;
    if (CoreRun !== 1'b1 || IMemWE !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL load2_run: Run=%b WE=%b Busy=%b required 1/0/0", CoreRun, IMemWE, Busy);
    end
    check_writes("load2");
  endtask

  task automatic test_zero_header();
    pulse_reload();
    checks++;
    if (CoreRun !== 1'b0 || InReady !== 1'b1 || IMemAddr !== 32'h0) begin
      errors++;
      $display("FAIL reload_done: Run=%b Ready=%b addr=%h required 0/1/0", CoreRun, InReady, IMemAddr);
    end
    send_word(32'd0);
    wait_cycles(2);
    checks++;
    if (CoreRun !== 1'b1 || InReady !== 1'b0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL zero_hdr: Run=%b Ready=%b Err=%b required 1/0/0", CoreRun, InReady, Error);
    end
    check_writes("zero_hdr");
  endtask

  task automatic test_overflow();
    pulse_reload();
    send_word(32'd257);
    checks++;
    if (Error !== 1'b1 || InReady !== 1'b0 || CoreRun !== 1'b0) begin
      errors++;
      $display("FAIL overflow: Err=%b Ready=%b Run=%b required 1/0/0", Error, InReady, CoreRun);
    end
    wait_cycles(4);
    checks++;
    if (Error !== 1'b1 || CoreRun !== 1'b0 || DbgState !== 2'd3) begin
      errors++;
      $display("FAIL overflow_sticky: Err=%b Run=%b state=%0d required 1/0/3", Error, CoreRun, DbgState);
    end
    check_writes("overflow");
    pulse_reload();
    checks++;
    if (Error !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL overflow_reload: Err=%b Ready=%b required 0/1", Error, InReady);
    end
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    wait_cycles(1);
    checks++;
    if (CoreRun !== 1'b1) begin
      errors++;
      $display("FAIL overflow_recover_run: Run=%b required 1", CoreRun);
    end
    check_writes("overflow_recover");
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [8];
    bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    pulse_reload();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i == 0) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL gaps_busy: Busy=%b required 1 after first header byte", Busy);
        end
      end
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge CLK);
          InValid = 1'b0;
          InByte  = 8'($urandom_range(0, 255));
        end
      end
      if (i == 6) begin
        checks++;
        if (obs_q.size() !== 0) begin
          errors++;
          $display("FAIL gaps_early_we: %0d writes before 4th data byte, required 0", obs_q.size());
        end
      end
    end
    checks++;
    if (IMemWE !== 1'b1 || IMemWData !== 32'h1234_5678 || IMemAddr !== 32'h0) begin
      errors++;
      $display("FAIL gaps_word: WE=%b data=%h addr=%h required 1/12345678/0", IMemWE, IMemWData, IMemAddr);
    end
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    wait_cycles(1);
    check_writes("gaps");
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    send_word(32'd2);
    send_word(32'h1111_2222);
    send_byte(8'hAA);
    send_byte(8'hBB);
    checks++;
    if (Busy !== 1'b1 || DbgState !== 2'd1) begin
      errors++;
      $display("FAIL midload_busy: Busy=%b state=%0d required 1/1", Busy, DbgState);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({InReady, IMemWE, CoreRun, Busy, Error} !== 5'b00000 || IMemAddr !== 32'h0 ||
        IMemWData !== 32'h0 || DbgState !== 2'd0) begin
      errors++;
      $display("FAIL midload_async_reset: R/WE/Run/Busy/Err=%b addr=%h data=%h state=%0d required 00000/0/0/0",
               {InReady, IMemWE, CoreRun, Busy, Error}, IMemAddr, IMemWData, DbgState);
    end
    wait_cycles(2);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_cycles(1);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({32'h0000_0000, 32'hCAFE_F00D});
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_cycles(1);
    checks++;
    if (CoreRun !== 1'b1) begin
      errors++;
      $display("FAIL midload_fresh_run: Run=%b required 1", CoreRun);
    end
    check_writes("midload_fresh");
  endtask

  initial begin
    RST_N   = 1'b0;
    InValid = 1'b0;
    InByte  = 8'h00;
    Reload  = 1'b0;
    test_reset();
    test_load_two();
    test_zero_header();
    test_overflow();
    test_gaps();
    test_reset_midload();
    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
